// File: rtl/dmi_arb_pkg.sv
// Shared DMI request/response types, op encodings and arbiter FSM states
// used by the DMI arbiter and its round-robin grant block.
package dmi_arb_pkg;

    localparam logic [1:0] DMI_OP_NOP   = 2'd0;
    localparam logic [1:0] DMI_OP_READ  = 2'd1;
    localparam logic [1:0] DMI_OP_WRITE = 2'd2;

    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_rsp_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/dmi_arb_rr.sv
// Two-way grant logic: rotating priority when RoundRobin is set,
// otherwise requester 0 always wins a tie.
module dmi_arb_rr #(
    parameter bit RoundRobin = 1'b1
) (
    input  logic       clock,
    input  logic       reset_ni,
    input  logic       clr_ni,
    input  logic [1:0] req_i,
    input  logic       ack_i,
    output logic [1:0] gnt_o,
    output logic       gnt_idx_o
);

    // prio_q is the requester favoured on a tie; it points away from the last winner
    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_idx_o = 1'b0;
        prio_d    = prio_q;
        if (!RoundRobin || req_i != 2'b11) begin
            gnt_idx_o = ~req_i[0];
        end else begin
            gnt_idx_o = prio_q;
        end
        gnt_o = {gnt_idx_o, ~gnt_idx_o} & {2{|req_i}};
        if (!clr_ni) begin
            prio_d = 1'b0;
        end else if (ack_i && RoundRobin) begin
            prio_d = ~gnt_idx_o;
        end
    end

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/dmi_arbiter.sv
// Arbitrates two DMI masters (JTAG DTM, DPI tap) onto a single rv_dm DMI port,
// keeping exactly one transaction outstanding at a time.
module dmi_arbiter
    import dmi_arb_pkg::*;
#(
    parameter bit RoundRobin = 1'b1
) (
    input  logic                clock,
    input  logic                reset_ni,
    input  logic                dmi_clr_ni,
    input  logic [1:0]          req_valid_i,
    input  dmi_req_t [1:0]      req_i,
    output logic [1:0]          req_ready_o,
    output logic [1:0]          rsp_valid_o,
    output dmi_rsp_t            rsp_o,
    input  logic [1:0]          rsp_ready_i,
    output logic                dm_req_valid_o,
    output dmi_req_t            dm_req_o,
    input  logic                dm_req_ready_i,
    input  logic                dm_rsp_valid_i,
    input  dmi_rsp_t            dm_rsp_i,
    output logic                dm_rsp_ready_o,
    output logic                busy_o,
    output logic                owner_o
);

    arb_state_e state_q, state_d;
    dmi_req_t   hold_q, hold_d;
    logic       owner_q, owner_d;
    logic [1:0] gnt;
    logic       gnt_idx;
    logic       grant_ack;

    dmi_arb_rr #(
        .RoundRobin (RoundRobin)
    ) u_rr (
        .clock     (clock),
        .reset_ni  (reset_ni),
        .clr_ni    (dmi_clr_ni),
        .req_i     (req_valid_i),
        .ack_i     (grant_ack),
        .gnt_o     (gnt),
        .gnt_idx_o (gnt_idx)
    );

    always_comb begin
        state_d        = state_q;
        hold_d         = hold_q;
        owner_d        = owner_q;
        grant_ack      = 1'b0;
        req_ready_o    = 2'b00;
        rsp_valid_o    = 2'b00;
        rsp_o          = '0;
        dm_req_valid_o = 1'b0;
        dm_req_o       = '0;
        dm_rsp_ready_o = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (|req_valid_i) begin
                    grant_ack   = 1'b1;
                    req_ready_o = gnt;
                    hold_d      = req_i[gnt_idx];
                    owner_d     = gnt_idx;
                    state_d     = ST_REQ;
                end
            end
            ST_REQ: begin
                dm_req_valid_o = 1'b1;
                dm_req_o       = hold_q;
                if (dm_req_ready_i) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                rsp_valid_o[owner_q] = dm_rsp_valid_i;
                rsp_o                = dm_rsp_i;
                dm_rsp_ready_o       = rsp_ready_i[owner_q];
                if (dm_rsp_valid_i && rsp_ready_i[owner_q]) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A DMI clear abandons the transaction, so no handshake may complete in that cycle
        if (!dmi_clr_ni) begin
            state_d        = ST_IDLE;
            hold_d         = '0;
            grant_ack      = 1'b0;
            req_ready_o    = 2'b00;
            rsp_valid_o    = 2'b00;
            dm_req_valid_o = 1'b0;
            dm_rsp_ready_o = 1'b0;
        end

        // Requesters must never see an accept while reset holds the flops
        if (!reset_ni) begin
            req_ready_o = 2'b00;
        end
    end

    always_ff @(posedge clock or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q <= ST_IDLE;
            hold_q  <= '0;
            owner_q <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            owner_q <= owner_d;
        end
    end

    assign busy_o  = (state_q != ST_IDLE);
    assign owner_o = owner_q;

endmodule

// File: tb/tb_dmi_arbiter.sv
// Self-checking bench for dmi_arbiter: directed scenarios plus randomized
// transactions, with a round-robin and a fixed-priority instance in lockstep.
module tb_dmi_arbiter;
    import dmi_arb_pkg::*;

    logic           clock = 1'b0;
    logic           reset_ni;
    logic           dmi_clr_ni;
    logic [1:0]     req_valid_i;
    dmi_req_t [1:0] req_i;
    logic [1:0]     rsp_ready_i;
    logic           dm_req_ready_i;
    logic           dm_rsp_valid_i;
    dmi_rsp_t       dm_rsp_i;
    logic           fpRdy;

    logic [1:0]     req_ready_o, rsp_valid_o;
    dmi_rsp_t       rsp_o;
    logic           dm_req_valid_o, dm_rsp_ready_o, busy_o, owner_o;
    dmi_req_t       dm_req_o;

    logic [1:0]     fp_req_ready_o, fp_rsp_valid_o;
    dmi_rsp_t       fp_rsp_o;
    logic           fp_dm_req_valid_o, fp_dm_rsp_ready_o, fp_busy_o, fp_owner_o;
    dmi_req_t       fp_dm_req_o;

    int   testsRun    = 0;
    int   testsFailed = 0;
    logic lastGnt     = 1'b1;

    always #5 clock = ~clock;

    dmi_arbiter #(.RoundRobin(1'b1)) dut (
        .clock          (clock),
        .reset_ni       (reset_ni),
        .dmi_clr_ni     (dmi_clr_ni),
        .req_valid_i    (req_valid_i),
        .req_i          (req_i),
        .req_ready_o    (req_ready_o),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_o          (rsp_o),
        .rsp_ready_i    (rsp_ready_i),
        .dm_req_valid_o (dm_req_valid_o),
        .dm_req_o       (dm_req_o),
        .dm_req_ready_i (dm_req_ready_i),
        .dm_rsp_valid_i (dm_rsp_valid_i),
        .dm_rsp_i       (dm_rsp_i),
        .dm_rsp_ready_o (dm_rsp_ready_o),
        .busy_o         (busy_o),
        .owner_o        (owner_o)
    );

    dmi_arbiter #(.RoundRobin(1'b0)) dut_fp (
        .clock          (clock),
        .reset_ni       (reset_ni),
        .dmi_clr_ni     (dmi_clr_ni),
        .req_valid_i    (req_valid_i),
        .req_i          (req_i),
        .req_ready_o    (fp_req_ready_o),
        .rsp_valid_o    (fp_rsp_valid_o),
        .rsp_o          (fp_rsp_o),
        .rsp_ready_i    ({2{fpRdy}}),
        .dm_req_valid_o (fp_dm_req_valid_o),
        .dm_req_o       (fp_dm_req_o),
        .dm_req_ready_i (dm_req_ready_i),
        .dm_rsp_valid_i (dm_rsp_valid_i),
        .dm_rsp_i       (dm_rsp_i),
        .dm_rsp_ready_o (fp_dm_rsp_ready_o),
        .busy_o         (fp_busy_o),
        .owner_o        (fp_owner_o)
    );

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        testsRun++;
        assert (observed === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic randBit();
        logic [31:0] t;
        t = $urandom;
        return t[0];
    endfunction

    function automatic dmi_req_t randReq();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        return '{addr: a[6:0], op: a[8:7], data: b};
    endfunction

    function automatic dmi_rsp_t randRsp();
        logic [31:0] a, b;
        a = $urandom;
        b = $urandom;
        return '{data: b, resp: a[1:0]};
    endfunction

    // One complete transaction; expected winner comes from the arbitration rules
    task automatic applyStimulus(input logic [1:0] v, input dmi_req_t r0, input dmi_req_t r1,
                                 input int reqStall, input int rspDelay, input int rdyStall,
                                 input dmi_rsp_t rsp);
        logic     exp, fpExp;
        dmi_req_t expReq, fpReq;
        exp     = (v == 2'b11) ? ~lastGnt : v[1];
        lastGnt = exp;
        fpExp   = v[0] ? 1'b0 : 1'b1;
        expReq  = exp ? r1 : r0;
        fpReq   = fpExp ? r1 : r0;

        req_valid_i = v;
        req_i[0]    = r0;
        req_i[1]    = r1;
        #2;
        checkOutput("grant_ready", req_ready_o, 2'b01 << exp);
        checkOutput("fp_grant_ready", fp_req_ready_o, 2'b01 << fpExp);
        checkOutput("idle_busy", busy_o, 0);
        checkOutput("idle_dm_valid", dm_req_valid_o, 0);
        step();
        req_valid_i = 2'b00;
        req_i[0]    = randReq();
        req_i[1]    = randReq();

        for (int i = 0; i <= reqStall; i++) begin
            dm_req_ready_i = (i == reqStall);
            dm_rsp_valid_i = randBit();
            #2;
            checkOutput("dm_req_valid", dm_req_valid_o, 1);
            checkOutput("dm_req_hold", dm_req_o, expReq);
            checkOutput("fp_dm_req", fp_dm_req_o, fpReq);
            checkOutput("req_ready_busy", req_ready_o, 0);
            checkOutput("rsp_pending", dm_rsp_ready_o, 0);
            checkOutput("rsp_valid_req", rsp_valid_o, 0);
            checkOutput("owner", owner_o, exp);
            checkOutput("fp_owner", fp_owner_o, fpExp);
            checkOutput("busy", busy_o, 1);
            step();
        end
        dm_req_ready_i = 1'b0;

        for (int j = 0; j <= rspDelay + rdyStall; j++) begin
            dm_rsp_valid_i    = (j >= rspDelay);
            dm_rsp_i          = (j >= rspDelay) ? rsp : randRsp();
            rsp_ready_i[exp]  = (j == rspDelay + rdyStall);
            rsp_ready_i[!exp] = randBit();
            fpRdy             = rsp_ready_i[exp];
            #2;
            checkOutput("rsp_valid", rsp_valid_o, {1'b0, dm_rsp_valid_i} << exp);
            if (dm_rsp_valid_i) checkOutput("rsp_data", rsp_o, rsp);
            checkOutput("dm_rsp_ready", dm_rsp_ready_o, rsp_ready_i[exp]);
            checkOutput("rsp_no_dm_req", dm_req_valid_o, 0);
            checkOutput("req_ready_rsp", req_ready_o, 0);
            step();
        end
        dm_rsp_valid_i = 1'b0;
        rsp_ready_i    = 2'b00;
        fpRdy          = 1'b0;
        #2;
        checkOutput("back_idle", busy_o, 0);
        checkOutput("fp_back_idle", fp_busy_o, 0);
    endtask

    initial begin
        logic [31:0] t;
        reset_ni       = 1'b0;
        dmi_clr_ni     = 1'b1;
        req_valid_i    = 2'b11;
        req_i[0]       = randReq();
        req_i[1]       = randReq();
        rsp_ready_i    = 2'b11;
        fpRdy          = 1'b1;
        dm_req_ready_i = 1'b1;
        dm_rsp_valid_i = 1'b1;
        dm_rsp_i       = randRsp();
        #3;
        checkOutput("rst_req_ready", req_ready_o, 0);
        checkOutput("rst_rsp_valid", rsp_valid_o, 0);
        checkOutput("rst_rsp", rsp_o, 0);
        checkOutput("rst_dm_req_valid", dm_req_valid_o, 0);
        checkOutput("rst_dm_req", dm_req_o, 0);
        checkOutput("rst_dm_rsp_ready", dm_rsp_ready_o, 0);
        checkOutput("rst_busy", busy_o, 0);
        checkOutput("rst_owner", owner_o, 0);
        checkOutput("rst_fp_req_ready", fp_req_ready_o, 0);
        step();
        step();
        req_valid_i    = 2'b00;
        rsp_ready_i    = 2'b00;
        fpRdy          = 1'b0;
        dm_req_ready_i = 1'b0;
        dm_rsp_valid_i = 1'b0;
        reset_ni       = 1'b1;
        #2;

        // Contention from reset: 0,1,0,1 round-robin, always 0 fixed
        for (int k = 0; k < 4; k++) begin
            applyStimulus(2'b11, randReq(), randReq(), 0, k % 2, 1, randRsp());
        end

        applyStimulus(2'b01, '{addr: 7'h11, op: DMI_OP_READ, data: 32'h0}, randReq(),
                      0, 0, 0, '{data: 32'h00000C82, resp: 2'd0});
        applyStimulus(2'b01, '{addr: 7'h05, op: DMI_OP_NOP, data: 32'hDEADBEEF}, randReq(),
                      5, 0, 0, randRsp());
        applyStimulus(2'b10, randReq(), '{addr: 7'h7F, op: DMI_OP_WRITE, data: 32'h12345678},
                      0, 0, 3, randRsp());

        // Clear during RSP after requester 0 won, so only a pointer reset favours 0 next
        req_valid_i = 2'b01;
        req_i[0]    = randReq();
        #2;
        checkOutput("clr_grant", req_ready_o, 2'b01);
        lastGnt = 1'b0;
        step();
        req_valid_i    = 2'b00;
        dm_req_ready_i = 1'b1;
        step();
        dm_req_ready_i = 1'b0;
        dm_rsp_valid_i = 1'b1;
        dm_rsp_i       = randRsp();
        #2;
        checkOutput("clr_pre_busy", busy_o, 1);
        dmi_clr_ni = 1'b0;
        step();
        dmi_clr_ni     = 1'b1;
        dm_rsp_valid_i = 1'b0;
        #2;
        checkOutput("clr_idle_busy", busy_o, 0);
        checkOutput("clr_fp_idle_busy", fp_busy_o, 0);
        checkOutput("clr_dm_rsp_ready", dm_rsp_ready_o, 0);
        lastGnt = 1'b1;
        applyStimulus(2'b11, randReq(), randReq(), 0, 0, 0, randRsp());

        for (int k = 0; k < 30; k++) begin
            t = $urandom_range(3, 1);
            applyStimulus(t[1:0], randReq(), randReq(), $urandom_range(0, 3),
                          $urandom_range(0, 3), $urandom_range(0, 3), randRsp());
        end

        // Asynchronous reset while waiting in REQ
        req_valid_i = 2'b10;
        req_i[1]    = randReq();
        #2;
        checkOutput("areset_grant", req_ready_o, 2'b10);
        step();
        req_valid_i    = 2'b11;
        dm_req_ready_i = 1'b0;
        #2;
        checkOutput("areset_pre_valid", dm_req_valid_o, 1);
        #1;
        reset_ni = 1'b0;
        #1;
        checkOutput("areset_dm_req_valid", dm_req_valid_o, 0);
        checkOutput("areset_dm_req", dm_req_o, 0);
        checkOutput("areset_req_ready", req_ready_o, 0);
        checkOutput("areset_busy", busy_o, 0);
        checkOutput("areset_owner", owner_o, 0);
        checkOutput("areset_rsp_valid", rsp_valid_o, 0);
        checkOutput("areset_fp_dm_req_valid", fp_dm_req_valid_o, 0);
        step();
        req_valid_i = 2'b00;
        reset_ni    = 1'b1;
        lastGnt     = 1'b1;
        #2;
        applyStimulus(2'b11, randReq(), randReq(), 1, 1, 1, randRsp());

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/dmi_arbiter.md
DMI_ARBITER -- requirements
Module: dmi_arbiter

Interface
REQ-001 Parameter RoundRobin, default 1'b1: 1 = rotating priority between requesters; 0 = requester 0 always wins.
REQ-002 Port clock  input  1  sole clock; all state on rising edge.
REQ-003 Port reset_ni  input  1  asynchronous active-low reset.
REQ-004 Port dmi_clr_ni  input  1  synchronous active-low clear from debug-module DMI reset.
REQ-005 Port req_valid_i  input  2  per-requester DMI request valid; [0] = JTAG DTM, [1] = DPI direct tap.
REQ-006 Port req_i  input  2 x dmi_req_t  per-requester request {addr 7, op 2, data 32}.
REQ-007 Port req_ready_o  output  2  per-requester request accept.
REQ-008 Port rsp_valid_o  output  2  per-requester response valid.
REQ-009 Port rsp_o  output  dmi_rsp_t  response {data 32, resp 2}, shared by both requesters; qualified by rsp_valid_o.
REQ-010 Port rsp_ready_i  input  2  per-requester response ready.
REQ-011 Port dm_req_valid_o / dm_req_o / dm_req_ready_i  out/out/in  1/dmi_req_t/1  request channel to rv_dm.
REQ-012 Port dm_rsp_valid_i / dm_rsp_i / dm_rsp_ready_o  in/in/out  1/dmi_rsp_t/1  response channel from rv_dm.
REQ-013 Port busy_o  output  1  high whenever FSM not IDLE; port owner_o  output  1  index of current owner.

Function
REQ-014 FSM states IDLE, REQ, RSP; exactly one transaction outstanding at any time.
REQ-015 IDLE: if any req_valid_i bit set, grant one, assert req_ready_o for the granted bit only, capture req_i into a holding register, record owner, go to REQ next cycle.
REQ-016 Grant with both valid: RoundRobin=1 grants the requester not granted last (requester 0 after reset); RoundRobin=0 grants requester 0.
REQ-017 req_ready_o is 0 in REQ and RSP; no combinational path from req_valid_i to dm_req_valid_o.
REQ-018 REQ: dm_req_valid_o = 1, dm_req_o = holding register; on dm_req_ready_i = 1 go to RSP; holding register stable while waiting.
REQ-019 Request latency: accept in cycle N, dm_req_valid_o high in cycle N+1.
REQ-020 RSP: rsp_valid_o[owner] = dm_rsp_valid_i, rsp_o = dm_rsp_i, dm_rsp_ready_o = rsp_ready_i[owner]; non-owner rsp_valid_o = 0.
REQ-021 RSP: on dm_rsp_valid_i && rsp_ready_i[owner] go to IDLE; a new grant is possible the following cycle, never in the same cycle.
REQ-022 dm_rsp_ready_o = 0 outside RSP; responses arriving in IDLE/REQ are left pending, not dropped.
REQ-023 All DMI ops (including nop, op = 0) are forwarded unchanged; no field decoding.
REQ-024 dmi_clr_ni = 0 in any state: next state IDLE, in-flight transaction abandoned, round-robin pointer reset to requester 0; this overrides REQ-015 to REQ-021 in that cycle.

Reset
REQ-025 On reset_ni low: state IDLE, holding register 0, owner 0, pointer favours requester 0.
REQ-026 On reset_ni low: all outputs 0 (req_ready_o, rsp_valid_o, dm_req_valid_o, dm_rsp_ready_o, busy_o, owner_o, buses).

Structure
REQ-027 dmi_req_t, dmi_rsp_t, DMI op encodings (nop 0, read 1, write 2) and the FSM state enum reside in package dmi_arb_pkg.
REQ-028 Grant logic is sub-module dmi_arb_rr (2-way round-robin with fixed-priority mode); FSM and datapath live in dmi_arbiter.

Verification
REQ-029 Requester 0 read, addr 0x11, both readies 1, dm returns data 0x00000C82 resp 0: dm_req_valid_o at N+1; requester 0 receives 0x00000C82; rsp_valid_o[1] stays 0.
REQ-030 Both valid continuously, RoundRobin=1, 4 transactions: grants are 0,1,0,1; with RoundRobin=0: 0,0,0,0.
REQ-031 dm_req_ready_i held 0 for 5 cycles after REQ entry: dm_req_o unchanged all 5 cycles; req_ready_o = 0 throughout.
REQ-032 Owner 1 rsp_ready_i = 0 for 3 cycles with dm_rsp_valid_i = 1: dm_rsp_ready_o = 0 for 3 cycles, then the handshake completes and the FSM returns to IDLE.
REQ-033 dmi_clr_ni pulsed low in RSP: IDLE next cycle; busy_o = 0; next grant goes to requester 0.
REQ-034 reset_ni asserted mid-REQ, asynchronously between edges: all outputs 0 immediately, without waiting for a clock edge.
